// File: rtl/interleaver_frame_ctrl.sv
// ---------------------------------------------------------------------------
// interleaver_frame_ctrl
//
// Frame sequencer in front of a FRAME_BITS-bit block interleaver.
// Accepts a valid/ready serial bit stream and loads exactly FRAME_BITS bits
// into the interleaver. A short frame (s_last before the final bit) is
// zero-padded. The controller then collects FRAME_BITS/OUT_W output nibbles
// and forwards them downstream, flagging the final one with m_last. Upstream
// is held off until the current frame has fully drained.
//
// Optional feature (macro ILV_CTRL_WDOG_EN): a drain watchdog aborts a frame
// to IDLE after WDOG_CYCLES cycles with no il_data_valid.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready    upstream handshake; s_bit data (MSB first), s_last
//   il_load_en         interleaver load strobe (combinational)
//   il_in_bit          interleaver data bit (combinational)
//   il_data_valid      interleaver output nibble valid
//   il_out_bits        interleaver output nibble
//   m_valid/m_data     downstream nibble (no backpressure), m_last on final
//   busy               controller not in IDLE
//   frame_done         1-cycle pulse when a frame has fully drained
//   frame_err          1-cycle pulse on any protocol error
//   frame_cnt          completed-frame counter, wraps
// ---------------------------------------------------------------------------
module interleaver_frame_ctrl #(
    parameter int FRAME_BITS  = 128,
    parameter int OUT_W       = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_bit,
    input  logic             s_last,
    output logic             il_load_en,
    output logic             il_in_bit,
    input  logic             il_data_valid,
    input  logic [OUT_W-1:0] il_out_bits,
    output logic             m_valid,
    output logic [OUT_W-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam int NIBS = FRAME_BITS / OUT_W;
    localparam int BW   = $clog2(FRAME_BITS + 1);
    localparam int NW   = $clog2(NIBS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, PAD, DRAIN, DONE} state_t;

    state_t           state_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [NW-1:0]    nib_cnt_q;
    logic             m_valid_q;
    logic [OUT_W-1:0] m_data_q;
    logic             m_last_q;
    logic             frame_done_q;
    logic             frame_err_q;
    logic [15:0]      frame_cnt_q;

    logic xfer;
    logic at_last_bit;

    // s_ready is qualified with rst_n so that every output reads 0 while
    // reset is held, even with s_valid driven high by upstream.
    assign s_ready     = rst_n & ((state_q == IDLE) | (state_q == LOAD));
    assign xfer        = s_valid & s_ready;
    assign il_load_en  = xfer | (state_q == PAD);
    assign il_in_bit   = xfer & s_bit;
    assign at_last_bit = (bit_cnt_q == BW'(FRAME_BITS - 1));

`ifdef ILV_CTRL_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_q;
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = (WDOG_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            nib_cnt_q    <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
`ifdef ILV_CTRL_WDOG_EN
            wdog_q       <= '0;
`endif
        end else begin
            // NOTE: pulse outputs default low every cycle; the case below only
            // raises them, so no branch can leave a stale 1 behind.
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;

            // A nibble arriving when we are not draining has nowhere to go.
            if (il_data_valid && state_q != DRAIN) begin
                frame_err_q <= 1'b1;
            end

`ifdef ILV_CTRL_WDOG_EN
            if (state_q != DRAIN) begin
                wdog_q <= '0;
            end
`endif

            case (state_q)
                IDLE, LOAD: begin
                    // bit_cnt_q is always 0 in IDLE, so the first xfer is bit 0.
                    if (xfer) begin
                        if (at_last_bit) begin
                            // Final bit wins over s_last: go straight to DRAIN.
                            state_q   <= DRAIN;
                            bit_cnt_q <= '0;
                            if (!s_last) begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            state_q   <= s_last ? PAD : LOAD;
                        end
                    end
                end

                PAD: begin
                    if (at_last_bit) begin
                        state_q   <= DRAIN;
                        bit_cnt_q <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                DRAIN: begin
                    if (il_data_valid) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= il_out_bits;
`ifdef ILV_CTRL_WDOG_EN
                        wdog_q    <= '0;
`endif
                        if (nib_cnt_q == NW'(NIBS - 1)) begin
                            m_last_q  <= 1'b1;
                            nib_cnt_q <= '0;
                            state_q   <= DONE;
                        end else begin
                            nib_cnt_q <= nib_cnt_q + 1'b1;
                        end
                    end
`ifdef ILV_CTRL_WDOG_EN
                    else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
                        // Interleaver went silent: abandon the frame.
                        frame_err_q <= 1'b1;
                        nib_cnt_q   <= '0;
                        wdog_q      <= '0;
                        state_q     <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end

                DONE: begin
                    frame_done_q <= 1'b1;
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                    state_q      <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_interleaver_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interleaver_frame_ctrl
//
// Directed bench for interleaver_frame_ctrl. A short table of single-cycle
// vectors covers reset state, handshake, stalls, stray il_data_valid and PAD
// entry; hand-written frame sequences cover full, gapped, short and
// unterminated frames plus an asynchronous mid-frame reset. The bench plays
// the interleaver itself, returning the frame's own nibbles in order.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_interleaver_frame_ctrl;

    localparam logic [127:0] FRAME = 128'hA5A5_5A5A_F0F0_0F0F_1234_ABCD_5678_EEEE;
    localparam int WDOG = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0, s_bit = 1'b0, s_last = 1'b0;
    logic       s_ready, il_load_en, il_in_bit;
    logic       il_data_valid = 1'b0;
    logic [3:0] il_out_bits = 4'h0;
    logic       m_valid, m_last, busy, frame_done, frame_err;
    logic [3:0] m_data;
    logic [15:0] frame_cnt;

    int n_vec = 0;
    int n_bad = 0;

    interleaver_frame_ctrl #(.FRAME_BITS(128), .OUT_W(4), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_bit(s_bit), .s_last(s_last),
        .il_load_en(il_load_en), .il_in_bit(il_in_bit),
        .il_data_valid(il_data_valid), .il_out_bits(il_out_bits),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] nib(input logic [127:0] f, input int k);
        if (k < 32) return f[127 - 4*k -: 4];
        return 4'h0;
    endfunction

    task automatic idle_inputs();
        s_valid = 1'b0; s_bit = 1'b0; s_last = 1'b0;
        il_data_valid = 1'b0; il_out_bits = 4'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sends one frame (bits 0..last_idx, s_last on last_idx; last_idx>127
    // means 128 bits with no s_last), returns the frame's nibbles while
    // draining, and checks the whole transaction.
    task automatic run_frame(input string tag, input int last_idx, input bit gap,
                             input int exp_pad, input int exp_err, input logic [15:0] exp_cnt);
        int nbits, idx, loads, bad_bit, pad, nk, mk, bad_nib, lastcnt, lastpos, done, errs, cyc;
        logic exp_bit;
        nbits = (last_idx < 128) ? last_idx + 1 : 128;
        idx = 0; loads = 0; bad_bit = 0; pad = 0; nk = 0; mk = 0; bad_nib = 0;
        lastcnt = 0; lastpos = -1; done = 0; errs = 0; cyc = 0;
        while (done == 0 && cyc < 3000) begin
            @(negedge clk);
            s_valid       = (idx < nbits) && !(gap && (cyc % 2 == 1));
            s_bit         = (idx < nbits) ? FRAME[127 - idx] : 1'b0;
            s_last        = (idx == last_idx);
            il_data_valid = (loads == 128) && (nk < 32) && !(gap && (cyc % 2 == 1));
            il_out_bits   = nib(FRAME, nk);
            #1;
            if (il_load_en) begin
                exp_bit = (loads < nbits) ? FRAME[127 - loads] : 1'b0;
                if (il_in_bit !== exp_bit) bad_bit++;
                if (!s_ready) pad++;
                loads++;
            end
            if (s_valid && s_ready) idx++;
            if (il_data_valid) nk++;
            @(posedge clk); #1;
            if (m_valid) begin
                if (m_data !== nib(FRAME, mk)) bad_nib++;
                mk++;
            end
            if (m_last) begin lastcnt++; lastpos = mk; end
            if (frame_done) done++;
            if (frame_err) errs++;
            cyc++;
        end
        check({tag, "_frame_done"}, done, 1);
        check({tag, "_loads"}, loads, 128);
        check({tag, "_load_bits_bad"}, bad_bit, 0);
        check({tag, "_pad_cycles"}, pad, exp_pad);
        check({tag, "_nibbles"}, mk, 32);
        check({tag, "_nibble_data_bad"}, bad_nib, 0);
        check({tag, "_m_last_count"}, lastcnt, 1);
        check({tag, "_m_last_pos"}, lastpos, 32);
        check({tag, "_frame_err"}, errs, exp_err);
        check({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
        check({tag, "_busy_after"}, busy, 0);
        // One quiet cycle: pulses drop, m_data holds the final nibble.
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        check({tag, "_hold"}, {m_valid, m_last, frame_done, m_data}, {3'b000, nib(FRAME, 31)});
    endtask

    typedef struct {
        logic       sv, sb, sl, dv;
        logic [3:0] ob;
        logic [2:0] e_comb;   // {s_ready, il_load_en, il_in_bit} before the edge
        logic [6:0] e_reg;    // {busy, m_valid, frame_err, m_data} after the edge
    } vec_t;

    vec_t vecs [10];

    initial begin
        //           sv    sb    sl    dv    ob     comb    reg
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b100, 7'b000_0000}; // idle after reset
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 3'b100, 7'b001_0000}; // stray dv in IDLE
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b100, 7'b000_0000}; // err is one pulse
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 3'b111, 7'b100_0000}; // bit 0 -> LOAD
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 3'b100, 7'b100_0000}; // stall
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'b110, 7'b100_0000}; // bit 1 = 0
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 3'b100, 7'b101_0000}; // stray dv in LOAD
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 3'b111, 7'b100_0000}; // short frame -> PAD
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b010, 7'b100_0000}; // PAD zero bit
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 3'b010, 7'b100_0000}; // PAD ignores upstream

        // Reset state
        #2;
        check("reset_outputs", {s_ready, il_load_en, il_in_bit, m_valid, m_data, m_last,
                                busy, frame_done, frame_err, frame_cnt}, '0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            s_valid = vecs[i].sv; s_bit = vecs[i].sb; s_last = vecs[i].sl;
            il_data_valid = vecs[i].dv; il_out_bits = vecs[i].ob;
            #1;
            check($sformatf("vec%0d_comb", i), {s_ready, il_load_en, il_in_bit}, vecs[i].e_comb);
            @(posedge clk); #1;
            check($sformatf("vec%0d_reg", i), {busy, m_valid, frame_err, m_data}, vecs[i].e_reg);
            @(negedge clk);
        end
        do_reset();

        run_frame("full", 127, 1'b0, 0, 0, 16'd1);
        run_frame("gapped", 127, 1'b1, 0, 0, 16'd2);
        run_frame("short", 63, 1'b0, 64, 0, 16'd3);
        run_frame("no_last", 999, 1'b0, 0, 1, 16'd4);

        // Asynchronous reset 20 bits into LOAD
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_bit = FRAME[127 - i]; s_last = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1; s_bit = 1'b1;
        check("pre_abort", {busy, frame_cnt}, {1'b1, 16'd4});
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {s_ready, il_load_en, il_in_bit, m_valid, m_data, m_last,
                                busy, frame_done, frame_err, frame_cnt}, '0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("after_abort", 127, 1'b0, 0, 0, 16'd1);

`ifdef ILV_CTRL_WDOG_EN
        begin
            int errs, err_at, mlast, cyc;
            errs = 0; err_at = -1; mlast = 0;
            for (int i = 0; i < 128; i++) begin
                @(negedge clk);
                s_valid = 1'b1; s_bit = FRAME[127 - i]; s_last = (i == 127);
            end
            @(negedge clk);
            idle_inputs();
            // The edge that loaded bit 127 was the previous posedge.
            for (cyc = 1; cyc <= WDOG + 20; cyc++) begin
                @(posedge clk); #1;
                if (frame_err) begin errs++; if (err_at < 0) err_at = cyc; end
                if (m_last) mlast++;
            end
            check("wdog_err_count", errs, 1);
            check("wdog_err_cycle", err_at, WDOG);
            check("wdog_m_last", mlast, 0);
            check("wdog_idle", busy, 0);
            check("wdog_frame_cnt", frame_cnt, 16'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
